// File: rtl/mc_sched_pkg.sv
// Shared state type and default widths for the Monte Carlo batch scheduler.
package mc_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      HOLD  = 2'd2
   } sched_state_e;

   localparam int DATA_W_DEF       = 18;
   localparam int MU_ADDR_W_DEF    = 9;
   localparam int SIGMA_ADDR_W_DEF = 10;
   localparam int PERF_W           = 16;

endpackage

// File: rtl/mc_batch_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority starts one past the last grant.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] cand;
   logic             found;
   int               j;

   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      cand  = '0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_q) + i;
         if (j >= N) j = j - N;
         cand = IDX_W'(j);
         if (en_i && !found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            ptr_d       = (j == N - 1) ? '0 : IDX_W'(j + 1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mc_batch_scheduler.sv
// Batch sequencer: option handshake, generator done tracking, table-write arbitration,
// ping-pong bank flip and core launch. Optional build-cycle counter under MC_PERF_COUNT_EN.
//   state | meaning
//   IDLE  | waiting for an option; cores may still be running
//   BUILD | generators filling the write bank
//   HOLD  | tables built, waiting for the running cores to finish
module mc_batch_scheduler
   import mc_sched_pkg::*;
#(
   parameter int EXP_MU_N     = 3,
   parameter int EXP_SIGMA_N  = 3,
   parameter int CORE_N       = 2,
   parameter int MU_ADDR_W    = MU_ADDR_W_DEF,
   parameter int SIGMA_ADDR_W = SIGMA_ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            iOptValid,
   output logic                            oOptReady,
   input  logic [DATA_W-1:0]               iMu,
   input  logic [DATA_W-1:0]               iS,
   input  logic [DATA_W-1:0]               iSigma,
   output logic [DATA_W-1:0]               oMu,
   output logic [DATA_W-1:0]               oS,
   output logic [DATA_W-1:0]               oSigma,
   output logic                            oStartExp,
   input  logic [EXP_MU_N-1:0]             iDoneExpMu,
   input  logic [EXP_SIGMA_N-1:0]          iDoneExpSigma,
   input  logic [EXP_MU_N-1:0]             iMuWrValid,
   input  logic [EXP_MU_N*MU_ADDR_W-1:0]   iMuWrAddr,
   input  logic [EXP_MU_N*DATA_W-1:0]      iMuWrData,
   output logic [EXP_MU_N-1:0]             oMuWrGnt,
   output logic                            oMuWrEn,
   output logic [MU_ADDR_W-1:0]            oMuWrAddr,
   output logic [DATA_W-1:0]               oMuWrData,
   input  logic [EXP_SIGMA_N-1:0]          iSigmaWrValid,
   input  logic [EXP_SIGMA_N*SIGMA_ADDR_W-1:0] iSigmaWrAddr,
   input  logic [EXP_SIGMA_N*DATA_W-1:0]   iSigmaWrData,
   output logic [EXP_SIGMA_N-1:0]          oSigmaWrGnt,
   output logic                            oSigmaWrEn,
   output logic [SIGMA_ADDR_W-1:0]         oSigmaWrAddr,
   output logic [DATA_W-1:0]               oSigmaWrData,
   output logic                            oBank,
   output logic                            oStartCores,
   input  logic [CORE_N-1:0]               iDoneCore,
   output logic                            oBusy,
   output logic [PERF_W-1:0]               oBuildCycles
);

   sched_state_e           state_q;
   logic                   opt_ready_q, start_exp_q, start_cores_q, bank_q, cores_busy_q;
   logic [DATA_W-1:0]      mu_q, s_q, sigma_q;
   logic [EXP_MU_N-1:0]    mu_mask_q;
   logic [EXP_SIGMA_N-1:0] sg_mask_q;
   logic [CORE_N-1:0]      core_mask_q;
   logic                   mu_wr_en_q, sg_wr_en_q;
   logic [MU_ADDR_W-1:0]   mu_wr_addr_q, mu_addr_sel;
   logic [SIGMA_ADDR_W-1:0] sg_wr_addr_q, sg_addr_sel;
   logic [DATA_W-1:0]      mu_wr_data_q, sg_wr_data_q, mu_data_sel, sg_data_sel;
   logic [EXP_MU_N-1:0]    mu_gnt;
   logic [EXP_SIGMA_N-1:0] sg_gnt;
   logic                   in_build, accept, build_done, cores_fin, cores_free, launch;

   assign in_build = (state_q == BUILD);
   assign accept   = iOptValid && opt_ready_q;

   // Current-cycle pulses count toward completion so the launch lands one cycle later.
   assign build_done = in_build
                       && (&(mu_mask_q | iDoneExpMu))
                       && (&(sg_mask_q | iDoneExpSigma))
                       && !(|iMuWrValid) && !(|iSigmaWrValid);
   assign cores_fin  = cores_busy_q && (&(core_mask_q | iDoneCore));
   assign cores_free = !cores_busy_q || cores_fin;
   assign launch     = cores_free && (build_done || (state_q == HOLD));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= IDLE;
         opt_ready_q   <= 1'b0;
         start_exp_q   <= 1'b0;
         start_cores_q <= 1'b0;
         bank_q        <= 1'b0;
         mu_q          <= '0;
         s_q           <= '0;
         sigma_q       <= '0;
         mu_mask_q     <= '0;
         sg_mask_q     <= '0;
      end else begin
         start_exp_q   <= 1'b0;
         start_cores_q <= 1'b0;
         case (state_q)
            IDLE: begin
               opt_ready_q <= !accept;
               if (accept) begin
                  mu_q        <= iMu;
                  s_q         <= iS;
                  sigma_q     <= iSigma;
                  start_exp_q <= 1'b1;
                  mu_mask_q   <= '0;
                  sg_mask_q   <= '0;
                  state_q     <= BUILD;
               end
            end
            BUILD: begin
               mu_mask_q   <= mu_mask_q | iDoneExpMu;
               sg_mask_q   <= sg_mask_q | iDoneExpSigma;
               opt_ready_q <= launch;
               if (launch) begin
                  bank_q        <= ~bank_q;
                  start_cores_q <= 1'b1;
                  state_q       <= IDLE;
               end else if (build_done) begin
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               opt_ready_q <= launch;
               if (launch) begin
                  bank_q        <= ~bank_q;
                  start_cores_q <= 1'b1;
                  state_q       <= IDLE;
               end
            end
            default: begin
               opt_ready_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   // A launch re-arms core tracking even when the previous run finishes in the same cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cores_busy_q <= 1'b0;
         core_mask_q  <= '0;
      end else if (launch) begin
         cores_busy_q <= 1'b1;
         core_mask_q  <= '0;
      end else if (cores_fin) begin
         cores_busy_q <= 1'b0;
         core_mask_q  <= '0;
      end else if (cores_busy_q) begin
         core_mask_q  <= core_mask_q | iDoneCore;
      end
   end

   rr_arbiter #(.N(EXP_MU_N)) u_mu_arb (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (in_build),
      .req_i (iMuWrValid),
      .gnt_o (mu_gnt)
   );

   rr_arbiter #(.N(EXP_SIGMA_N)) u_sg_arb (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (in_build),
      .req_i (iSigmaWrValid),
      .gnt_o (sg_gnt)
   );

   always_comb begin
      mu_addr_sel = '0;
      mu_data_sel = '0;
      sg_addr_sel = '0;
      sg_data_sel = '0;
      for (int i = 0; i < EXP_MU_N; i++) begin
         if (mu_gnt[i]) begin
            mu_addr_sel = iMuWrAddr[i*MU_ADDR_W +: MU_ADDR_W];
            mu_data_sel = iMuWrData[i*DATA_W +: DATA_W];
         end
      end
      for (int i = 0; i < EXP_SIGMA_N; i++) begin
         if (sg_gnt[i]) begin
            sg_addr_sel = iSigmaWrAddr[i*SIGMA_ADDR_W +: SIGMA_ADDR_W];
            sg_data_sel = iSigmaWrData[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mu_wr_en_q   <= 1'b0;
         mu_wr_addr_q <= '0;
         mu_wr_data_q <= '0;
         sg_wr_en_q   <= 1'b0;
         sg_wr_addr_q <= '0;
         sg_wr_data_q <= '0;
      end else begin
         mu_wr_en_q <= |mu_gnt;
         sg_wr_en_q <= |sg_gnt;
         if (|mu_gnt) begin
            mu_wr_addr_q <= mu_addr_sel;
            mu_wr_data_q <= mu_data_sel;
         end
         if (|sg_gnt) begin
            sg_wr_addr_q <= sg_addr_sel;
            sg_wr_data_q <= sg_data_sel;
         end
      end
   end

`ifdef MC_PERF_COUNT_EN
   logic [PERF_W-1:0] perf_cnt_q, build_cycles_q, perf_inc;

   assign perf_inc = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + 1'b1;

   // build_done is exactly the last BUILD cycle, so latch the count including it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         perf_cnt_q     <= '0;
         build_cycles_q <= '0;
      end else begin
         if (accept)        perf_cnt_q <= '0;
         else if (in_build) perf_cnt_q <= perf_inc;
         if (build_done)    build_cycles_q <= perf_inc;
      end
   end

   assign oBuildCycles = build_cycles_q;
`else
   assign oBuildCycles = '0;
`endif

   assign oOptReady    = opt_ready_q;
   assign oMu          = mu_q;
   assign oS           = s_q;
   assign oSigma       = sigma_q;
   assign oStartExp    = start_exp_q;
   assign oMuWrGnt     = mu_gnt;
   assign oMuWrEn      = mu_wr_en_q;
   assign oMuWrAddr    = mu_wr_addr_q;
   assign oMuWrData    = mu_wr_data_q;
   assign oSigmaWrGnt  = sg_gnt;
   assign oSigmaWrEn   = sg_wr_en_q;
   assign oSigmaWrAddr = sg_wr_addr_q;
   assign oSigmaWrData = sg_wr_data_q;
   assign oBank        = bank_q;
   assign oStartCores  = start_cores_q;
   assign oBusy        = (state_q != IDLE) || cores_busy_q;

endmodule

// File: doc/mc_batch_scheduler.md
Name: mc_batch_scheduler

Overview:
- Sequences one Monte Carlo batch: accepts option parameters (Mu, S, Sigma) by handshake and launches the ExpMu and ExpSigma generator banks.
- Collects the done pulses from every generator instance and arbitrates each bank's table writes round-robin.
- Flips the ping-pong table bank and launches the MC cores, overlapping the next table build with the current core run.
- Sits between the option input and the generator/core array; the top level keeps only wiring.

Parameters:
EXP_MU_N, 3, number of ExpMu generator instances
EXP_SIGMA_N, 3, number of ExpSigma generator instances
CORE_N, 2, number of MC cores
MU_ADDR_W, 9, ExpMu table address width (log2 T)
SIGMA_ADDR_W, 10, ExpSigma table address width (pathWidth)
DATA_W, 18, table word / option field width

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
iOptValid  in  1  new option present
oOptReady  out  1  option accepted when iOptValid && oOptReady
iMu / iS / iSigma  in  DATA_W each  option fields
oMu / oS / oSigma  out  DATA_W each  registered fields to generators
oStartExp  out  1  one-cycle start pulse to all generators
iDoneExpMu  in  EXP_MU_N  per-instance done pulses
iDoneExpSigma  in  EXP_SIGMA_N  per-instance done pulses
iMuWrValid  in  EXP_MU_N  write requests
iMuWrAddr  in  EXP_MU_N*MU_ADDR_W  packed write addresses
iMuWrData  in  EXP_MU_N*DATA_W  packed write data
oMuWrGnt  out  EXP_MU_N  one-hot grant; requester holds addr/data/valid until granted
oMuWrEn / oMuWrAddr / oMuWrData  out  1 / MU_ADDR_W / DATA_W  to ExpMu table RAM
iSigmaWr* / oSigmaWrGnt / oSigmaWr*  same set for the Sigma bank (SIGMA_ADDR_W)
oBank  out  1  bank being written; cores read ~oBank
oStartCores  out  1  one-cycle start pulse to all cores
iDoneCore  in  CORE_N  per-core done pulses
oBusy  out  1  state != IDLE or cores running
oBuildCycles  out  16  see Optional Feature

Behaviour:
- Reset values: all outputs 0; oBank=0; done masks cleared; coresBusy=0; state IDLE. Reset mid-batch abandons the batch. Done pulses and write requests arriving after reset are ignored, with no grants, because state is IDLE.
- States: IDLE, BUILD, HOLD.
- IDLE: oOptReady=1.
  - On accept at cycle c: oMu/oS/oSigma load and oStartExp=1 at c+1 for exactly one cycle.
  - Done masks clear at c+1; state moves to BUILD.
- BUILD:
  - Done pulses are OR'd into sticky masks muMask and sigmaMask.
  - Build-complete = both masks all ones && no iMuWrValid/iSigmaWrValid bits set.
  - On build-complete at cycle k with coresBusy=0: oBank toggles, oStartCores=1 at k+1 for one cycle, coresBusy=1, state returns to IDLE.
  - On build-complete with coresBusy=1: go to HOLD.
- HOLD: wait for coresBusy=0, then the same launch action and return to IDLE. oOptReady=0.
- Cores tracking:
  - Sticky coreMask collects iDoneCore.
  - When all ones, coresBusy clears next cycle and coreMask clears.
  - If the final core done and build-complete coincide in BUILD, launch occurs at k+1. The cycle-k core completion counts; no extra HOLD cycle.
- Done pulses outside BUILD are ignored. A repeated done from one instance is idempotent.
- Arbiters, one per bank, independent:
  - Round-robin with the pointer starting at instance 0 after reset.
  - Priority starts at last grant +1, wrapping at N-1 -> 0.
  - At most one grant per cycle. Grant is combinational from the current valids.
  - oWrEn/oWrAddr/oWrData are registered, valid the cycle after grant.
  - Grants are issued only in BUILD.
- Latency option-accept -> oStartExp: 1 cycle. Build-complete -> oStartCores: 1 cycle.

Optional Feature:
- MC_PERF_COUNT_EN defined:
  - A 16-bit counter runs while state==BUILD; it saturates at 0xFFFF.
  - On leaving BUILD it latches to oBuildCycles. The counter clears on the next oStartExp.
- Undefined: oBuildCycles is tied to 0; no counter logic is present.

Decomposition:
- Package mc_sched_pkg: state enum (IDLE, BUILD, HOLD), default width constants (DATA_W=18, MU_ADDR_W=9, SIGMA_ADDR_W=10), perf counter width 16.
- Sub-module rr_arbiter (parameter N, request vector in, one-hot grant out, pointer register), instantiated once per bank.

Test Plan:
- Reset, then iOptValid=1 with iMu=0x00100: oStartExp high exactly at accept+1, oMu=0x00100, oOptReady=0 from the cycle after accept.
- Done pulses for Mu instances 2,0,1 and Sigma instances 1,2,0 in separate cycles, cores idle: oStartCores one cycle after the last pulse, oBank 0->1.
- All three Mu generators request writes continuously: grants rotate 0,1,2,0; each granted word appears on oMuWrAddr/oMuWrData one cycle later.
- Second option built while cores run (iDoneCore=00): state HOLD, no oStartCores. iDoneCore pulses 01 then 10: launch one cycle after the second pulse, oBank 1->0.
- Final core done and final generator done in the same cycle: launch at the next cycle, no HOLD entry.
- RST asserted mid-BUILD, then a stray done pulse: all outputs 0, oBank=0, no grants, no start pulse; with MC_PERF_COUNT_EN defined, a 40-cycle build yields oBuildCycles=40.
